// File: rtl/line_shift_out_if.sv
// Stream-side bundle for line_shift_out: line capture request, word stream and status.
// The master side (client) drives load/line_packed/out_ready; the slave side (unloader) drives the rest.
interface line_shift_out_if #(
  parameter int LENGTH = 8,
  parameter int WIDTH  = 8,
  parameter int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
);
  logic                    load;
  logic [LENGTH*WIDTH-1:0] line_packed;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    done;

  modport master (
    output load, line_packed, out_ready,
    input  busy, out_valid, out_data, out_idx, done
  );

  modport slave (
    input  load, line_packed, out_ready,
    output busy, out_valid, out_data, out_idx, done
  );
endinterface

// File: rtl/line_shift_out.sv
// Parallel-in, serial-out line unloader: captures a packed cache line, streams word LENGTH-1 down to 0.
// Optional LINE_SHIFT_OUT_SKIP_ERASED_EN drops all-ones (erased) words instead of presenting them.
module line_shift_out #(
  parameter int LENGTH = 8,
  parameter int WIDTH  = 8,
  parameter int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  line_shift_out_if.slave bus
);
  localparam int CNT_W = $clog2(LENGTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  q_reg [LENGTH];
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              done_reg, done_next;
  logic              accept, advance;
  logic              busy_c, valid_c;

`ifdef LINE_SHIFT_OUT_SKIP_ERASED_EN
  logic erased;
  assign erased = (q_reg[LENGTH-1] == {WIDTH{1'b1}});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    busy_c     = 1'b0;
    valid_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          accept     = 1'b1;
          count_next = CNT_W'(LENGTH);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
`ifdef LINE_SHIFT_OUT_SKIP_ERASED_EN
        // Erased words are never offered; they shift out on their own, one per cycle.
        valid_c = ~erased;
        advance = erased | bus.out_ready;
`else
        valid_c = 1'b1;
        advance = bus.out_ready;
`endif
        if (advance) begin
          count_next = count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word registers: q[LENGTH-1] is the head; all-ones refills from the bottom.
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_word
    if (gi == 0) begin : g_bottom
      always_ff @(posedge clk) begin
        if (rst)
          q_reg[gi] <= {WIDTH{1'b1}};
        else if (accept)
          q_reg[gi] <= bus.line_packed[WIDTH*gi +: WIDTH];
        else if (advance)
          q_reg[gi] <= {WIDTH{1'b1}};
      end
    end else begin : g_upper
      always_ff @(posedge clk) begin
        if (rst)
          q_reg[gi] <= {WIDTH{1'b1}};
        else if (accept)
          q_reg[gi] <= bus.line_packed[WIDTH*gi +: WIDTH];
        else if (advance)
          q_reg[gi] <= q_reg[gi-1];
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = valid_c;
  assign bus.out_data  = q_reg[LENGTH-1];
  assign bus.out_idx   = (state_reg == SHIFT) ? IDX_W'(count_reg - CNT_W'(1)) : '0;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_line_shift_out.sv
// Self-checking bench for line_shift_out: directed scenarios plus random traffic against a queue model.
module tb_line_shift_out;
  localparam int L = 8;
  localparam int W = 8;
`ifdef LINE_SHIFT_OUT_SKIP_ERASED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_shift_out_if #(.LENGTH(L), .WIDTH(W)) bus ();

  line_shift_out #(.LENGTH(L), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of words still owed to the sink, head first, plus the pending done flag.
  logic [W-1:0] mq_d[$];
  int           mq_i[$];
  logic         m_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [L*W-1:0] mk_inc(input logic [W-1:0] base);
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[W*i +: W] = base + W'(i);
    return v;
  endfunction

  function automatic logic [L*W-1:0] mk_fill(input logic [W-1:0] w);
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[W*i +: W] = w;
    return v;
  endfunction

  task automatic cyc(input logic ld, input logic [L*W-1:0] ln, input logic rdy, input logic r);
    logic erased, xfer;
    logic exp_valid;
    bus.load        = ld;
    bus.line_packed = ln;
    bus.out_ready   = rdy;
    rst             = r;
    m_done          = 1'b0;
    if (r) begin
      mq_d.delete();
      mq_i.delete();
    end else if (mq_d.size() == 0) begin
      if (ld) begin
        for (int i = L - 1; i >= 0; i--) begin
          mq_d.push_back(ln[W*i +: W]);
          mq_i.push_back(i);
        end
      end
    end else begin
      erased = SKIP && (mq_d[0] == {W{1'b1}});
      xfer   = erased || rdy;
      if (xfer) begin
        void'(mq_d.pop_front());
        void'(mq_i.pop_front());
        if (mq_d.size() == 0) m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    exp_valid = (mq_d.size() != 0) && !(SKIP && mq_d[0] == {W{1'b1}});
    check("busy", 32'(bus.busy), 32'(mq_d.size() != 0));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("done", 32'(bus.done), 32'(m_done));
    check("out_data", 32'(bus.out_data), (mq_d.size() != 0) ? 32'(mq_d[0]) : 32'hFF);
    check("out_idx", 32'(bus.out_idx), (mq_i.size() != 0) ? 32'(mq_i[0]) : 32'd0);
    $display("t=%0t ld=%0b rdy=%0b rst=%0b busy=%0b valid=%0b data=%02h idx=%0d done=%0b",
             $time, ld, rdy, r, bus.busy, bus.out_valid, bus.out_data, bus.out_idx, bus.done);
  endtask

  initial begin
    logic [L*W-1:0] line_a, line_b, line_aa, line_skip, rl;
    int n_xfer;
    line_a    = mk_inc(8'h10);
    line_b    = mk_inc(8'h20);
    line_aa   = mk_fill(8'hAA);
    line_skip = line_a;
    line_skip[W*2 +: W] = 8'hFF;
    line_skip[W*5 +: W] = 8'hFF;
    bus.load = 1'b0; bus.line_packed = '0; bus.out_ready = 1'b0;

    // Reset state
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);

    // Plain unload, ready held high
    cyc(1, line_a, 1, 0);
    for (int c = 0; c < 9; c++) cyc(0, '0, 1, 0);
    check("plain_idle_after", 32'(bus.busy), 32'd0);

    // Backpressure on cycles 2-4
    cyc(1, line_a, 1, 0);
    cyc(0, '0, 1, 0);
    for (int c = 0; c < 3; c++) cyc(0, '0, 0, 0);
    for (int c = 0; c < 8; c++) cyc(0, '0, 1, 0);

    // Load while busy is ignored; line_packed changes after capture are ignored
    cyc(1, line_a, 1, 0);
    cyc(0, line_aa, 1, 0);
    cyc(1, line_aa, 1, 0);
    for (int c = 0; c < 7; c++) cyc(0, line_aa, 1, 0);

    // Back-to-back: second load in the done cycle
    cyc(1, line_a, 1, 0);
    for (int c = 0; c < 8; c++) cyc(0, '0, 1, 0);
    check("b2b_done_cycle", 32'(bus.done), 32'd1);
    cyc(1, line_b, 1, 0);
    check("b2b_first_word", 32'(bus.out_data), 32'h27);
    for (int c = 0; c < 9; c++) cyc(0, '0, 1, 0);

    // Reset mid-unload, then a normal unload
    cyc(1, line_a, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 1);
    check("rst_mid_data", 32'(bus.out_data), 32'hFF);
    for (int c = 0; c < 3; c++) cyc(0, '0, 1, 0);
    cyc(1, line_b, 1, 0);
    for (int c = 0; c < 9; c++) cyc(0, '0, 1, 0);

    // Erased words 2 and 5: six or eight transfers depending on build
    n_xfer = 0;
    cyc(1, line_skip, 1, 0);
    for (int c = 0; c < 9; c++) begin
      if (bus.out_valid) n_xfer++;
      cyc(0, '0, 1, 0);
    end
    check("skip_xfer_count", 32'(n_xfer), SKIP ? 32'd6 : 32'd8);

    // All-erased line
    cyc(1, mk_fill(8'hFF), 1, 0);
    for (int c = 0; c < 10; c++) cyc(0, '0, 1, 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < L; i++)
        rl[W*i +: W] = ($urandom_range(0, 5) == 0) ? 8'hFF : W'($urandom);
      cyc(($urandom_range(0, 3) == 0), rl, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_shift_out.md
Name: line_shift_out

Overview:
- Parallel-in, serial-out counterpart of the cache's word-enabled fill shift register.
- Captures a full packed cache line in one cycle, then presents it one word per transfer on a valid/ready stream. The stream feeds write-back to the memory bus.
- Words are emitted oldest-first, in the same order the fill path shifted them in: word LENGTH-1 first, word 0 last.

Parameters:
- LENGTH, 8, number of words per line.
- WIDTH, 8, bits per word.
- IDX_W, $clog2(LENGTH) (minimum 1), width of out_idx.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  request to capture line_packed; accepted only when busy=0.
- line_packed  input  LENGTH*WIDTH  line to unload; word i at bits [WIDTH*i +: WIDTH].
- busy  output  1  high while a line is held and not fully emitted.
- out_valid  output  1  out_data/out_idx carry a word.
- out_ready  input  1  sink accepts the word this cycle.
- out_data  output  WIDTH  current word, always driven from the top register.
- out_idx  output  IDX_W  index i of the word on out_data.
- done  output  1  one-cycle pulse after the final word transfers.

Behaviour:
- Reset values:
  - Internal word registers q[0..LENGTH-1] = all ones.
  - busy=0, out_valid=0, done=0, out_idx=0.
  - out_data = all ones (q[LENGTH-1]).
- States:
  - IDLE: busy=0, out_valid=0.
  - SHIFT: busy=1, out_valid=1, except as modified by the optional feature.
- IDLE with load=1 at an edge:
  - q[i] <= line_packed word i.
  - Remaining count <= LENGTH; out_idx <= LENGTH-1.
  - Go to SHIFT.
  - First word is visible the cycle after load (latency 1).
- IDLE with load=0: hold; done=0.
- SHIFT, transfer = out_valid & out_ready at an edge:
  - q[i] <= q[i-1] for i>=1; q[0] <= all ones.
  - Count decrements; out_idx decrements.
- SHIFT, out_valid=1 & out_ready=0: out_data and out_idx held stable. This is a no-retraction rule: valid never drops until a transfer occurs.
- Final transfer (count==1) at edge N:
  - At edge N+1 state is IDLE, busy=0, out_valid=0, done=1 for exactly that cycle.
  - out_idx wraps to 0.
- load in the done cycle is accepted (IDLE). done still pulses for the previous line only.
- load while busy=1 is ignored; the captured line is not disturbed.
- line_packed is sampled only at the accepting edge; later changes have no effect.
- rst asserted mid-unload:
  - Aborts at that edge to reset values.
  - No done pulse; remaining words are discarded.
- Arithmetic: count is wide enough to hold LENGTH. out_idx = count-1 truncated to IDX_W. LENGTH=1 is legal (a single-word line).

Optional Feature:
- Macro: LINE_SHIFT_OUT_SKIP_ERASED_EN.
- Defined:
  - In SHIFT, if q[LENGTH-1] == all ones (the erased/reset word value), out_valid=0 for that cycle.
  - The word is dropped: shift and decrement occur unconditionally at the edge, one skipped word per cycle.
  - If the final word is skipped, done still pulses the next cycle.
  - A line of all-ones words emits nothing and produces done LENGTH+1 cycles after load.
- Undefined:
  - Every word is presented, including all-ones words.
  - No comparator logic is present.

Test Plan:
- Plain unload: LENGTH=8, WIDTH=8, line words i=0..7 = 8'h10+i, load once, out_ready=1.
  - Words 8'h17..8'h10 on consecutive cycles 1..8, out_idx 7..0.
  - done=1 on cycle 9, busy=0.
- Backpressure: same line, out_ready low on cycles 2-4.
  - out_data holds 8'h16 and out_idx holds 6 with valid=1 through the stall.
  - Total 8 transfers, correct order, done one cycle after the last.
- Load while busy: second load with 8'hAA words at cycle 3.
  - Ignored; stream remains 8'h17..8'h10.
- Back-to-back: load a second line (words 8'h20+i) in the done cycle.
  - 8'h27 appears the next cycle.
  - No gap beyond the single done cycle.
- Reset mid-op: rst at cycle 4.
  - Next cycle busy=0, out_valid=0, out_data=8'hFF, done never pulses.
  - A subsequent load unloads normally.
- Skip (macro defined): words 2 and 5 = 8'hFF.
  - Only six transfers (idx 7,6,4,3,1,0).
  - done on cycle 9 with out_ready=1 throughout.
  - With the macro undefined, the same stimulus gives eight transfers.
